// File: rtl/cmp_seq_arbiter.sv
// cmp_seq_arbiter: two-requester round-robin front end for a nibble-serial cascade comparator.
// Optional build macro SIGNED_CMP_EN selects two's-complement compare (default build: unsigned).
`timescale 1ns/1ps

module bitAssian (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       firstG,
    input  logic       firstL,
    input  logic       firstE,
    output logic       G,
    output logic       L,
    output logic       E
);
    // An unequal nibble decides; an equal nibble passes the lower-order result through.
    assign G = (a > b) | ((a == b) & firstG);
    assign L = (a < b) | ((a == b) & firstL);
    assign E = (a == b) & firstE;
endmodule

module cmp_seq_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [4*NIBBLES-1:0] a0,
    input  logic [4*NIBBLES-1:0] b0,
    input  logic                 req1,
    input  logic [4*NIBBLES-1:0] a1,
    input  logic [4*NIBBLES-1:0] b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 busy,
    output logic                 done,
    output logic                 owner,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opA, opB;
    logic             gReg, lReg, eReg;
    logic             favoured;

    logic [3:0] sliceA, sliceB;
    logic       cascG, cascL, cascE;
    logic       sliceG, sliceL, sliceE;
    logic       grantIdx;

    // Captured operands shift right each RUN cycle, so nibble cnt is always at [3:0].
    // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        sliceA = opA[3:0];
        sliceB = opB[3:0];
`ifdef SIGNED_CMP_EN
        if (cnt == LAST_CNT) begin
            sliceA[3] = ~opA[3];
            sliceB[3] = ~opB[3];
        end
`endif
        if (cnt == '0) begin
            {cascG, cascL, cascE} = 3'b001;
        end else begin
            {cascG, cascL, cascE} = {gReg, lReg, eReg};
        end
    end

    bitAssian uSlice (
        .a      (sliceA),
        .b      (sliceB),
        .firstG (cascG),
        .firstL (cascL),
        .firstE (cascE),
        .G      (sliceG),
        .L      (sliceL),
        .E      (sliceE)
    );

    // Contested grants go to the favoured requester; the favour then passes to the other one.
    assign grantIdx = (req0 && req1) ? favoured : req1;

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opA      <= '0;
            opB      <= '0;
            gReg     <= 1'b0;
            lReg     <= 1'b0;
            eReg     <= 1'b0;
            favoured <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            owner    <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        owner <= grantIdx;
                        gnt0  <= ~grantIdx;
                        gnt1  <= grantIdx;
                        cnt   <= '0;
                        opA   <= grantIdx ? a1 : a0;
                        opB   <= grantIdx ? b1 : b0;
                        if (req0 && req1) favoured <= ~grantIdx;
                    end
                end
                RUN: begin
                    gReg <= sliceG;
                    lReg <= sliceL;
                    eReg <= sliceE;
                    cnt  <= cnt + 1'b1;
                    opA  <= opA >> 4;
                    opB  <= opB >> 4;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                        done  <= 1'b1;
                        gt    <= sliceG;
                        lt    <= sliceL;
                        eq    <= sliceE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_seq_arbiter.sv
// Self-checking bench for cmp_seq_arbiter: reset, vector table, hand-written corner sequences
// and randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps

module tb_cmp_seq_arbiter;
    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, busy, done, owner, gt, lt, eq;

    int errors = 0;
    int checks = 0;

    always #100 clk = ~clk;

    cmp_seq_arbiter #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .done  (done),
        .owner (owner),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    typedef struct {
        bit          who;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  exp;   // {gt, lt, eq}
    } vecT;

    vecT vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] expCmp(input logic [15:0] x, input logic [15:0] y);
        int sx, sy;
`ifdef SIGNED_CMP_EN
        sx = int'($signed(x));
        sy = int'($signed(y));
`else
        sx = int'(x);
        sy = int'(y);
`endif
        if (sx > sy) return 3'b100;
        if (sx < sy) return 3'b010;
        return 3'b001;
    endfunction

    task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
    endtask

    // Called at a negedge while the DUT is IDLE and the winner's request is already driven.
    task automatic runCompare(input string tag, input bit expOwner, input logic [2:0] expRes,
                              input bit dropReq);
        int edges;
        @(negedge clk);
        check({tag, " gnt"}, {30'd0, gnt0, gnt1}, expOwner ? 32'd1 : 32'd2);
        check({tag, " busy@gnt"}, busy, 1);
        check({tag, " owner@gnt"}, owner, expOwner);
        if (dropReq) begin
            if (expOwner) begin
                req1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom);
            end else begin
                req0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
            end
        end
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (edges == 1) check({tag, " gnt pulse width"}, {gnt0, gnt1}, 0);
        end while (!done && edges < 12);
        check({tag, " done latency"}, edges, NIB);
        check({tag, " result"}, {gt, lt, eq}, expRes);
        check({tag, " owner@done"}, owner, expOwner);
        check({tag, " busy@done"}, busy, 1);
        @(negedge clk);
        check({tag, " done/busy after"}, {done, busy}, 0);
        check({tag, " result hold"}, {gt, lt, eq}, expRes);
    endtask

    initial begin
        bit          pend0, pend1, fav, w;
        logic [15:0] ra0, rb0, ra1, rb1;

        vecs[0] = '{1'b0, 16'h1234, 16'h1234, 3'b001};
        vecs[1] = '{1'b1, 16'h0001, 16'h0000, 3'b100};
        vecs[2] = '{1'b1, 16'h0FFF, 16'h1000, 3'b010};
        vecs[3] = '{1'b0, 16'h00F0, 16'h000F, 3'b100};
        vecs[4] = '{1'b1, 16'h7FFF, 16'h7FFE, 3'b100};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 3'b001};
        vecs[6] = '{1'b0, 16'h1000, 16'h0FFF, 3'b100};
        vecs[7] = '{1'b1, 16'h0010, 16'h0100, 3'b010};

        // T1: rst held with req0 high; rst wins, then the request is granted.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        issue(1'b0, 16'h5555, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset outputs", {gnt0, gnt1, busy, done, owner, gt, lt, eq}, 0);
        end
        rst = 1'b0;
        runCompare("T1 post-reset", 1'b0, 3'b001, 1'b1);

        // Table of single-requester compares (T2, T3 and more).
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].who, vecs[i].a, vecs[i].b);
            runCompare($sformatf("vec%0d", i), vecs[i].who, vecs[i].exp, 1'b1);
        end

        // T4: both requesters high from reset, kept high after each grant.
        rst = 1'b1;
        issue(1'b0, 16'h0002, 16'h0001);
        issue(1'b1, 16'h0001, 16'h0002);
        @(negedge clk);
        rst = 1'b0;
        runCompare("T4 first", 1'b0, 3'b100, 1'b0);
        runCompare("T4 second", 1'b1, 3'b010, 1'b0);
        runCompare("T4 third", 1'b0, 3'b100, 1'b1);
        req1 = 1'b0;

        // T5: reset during the second RUN cycle aborts the compare.
        issue(1'b0, 16'h4321, 16'h1234);
        @(negedge clk);
        check("T5 gnt0", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("T5 abort outputs", {gnt0, gnt1, busy, done, owner, gt, lt, eq}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("T5 no done after abort", {gnt0, gnt1, busy, done}, 0);
        end
        issue(1'b1, 16'h0100, 16'h00FF);
        runCompare("T5 fresh req1", 1'b1, 3'b100, 1'b1);

        // T6: sign-sensitive operands.
        issue(1'b0, 16'h8000, 16'h0001);
`ifdef SIGNED_CMP_EN
        runCompare("T6 8000 vs 0001", 1'b0, 3'b010, 1'b1);
`else
        runCompare("T6 8000 vs 0001", 1'b0, 3'b100, 1'b1);
`endif
        issue(1'b0, 16'hFFFF, 16'hFFFE);
        runCompare("T6 FFFF vs FFFE", 1'b0, 3'b100, 1'b1);

        // Randomized traffic: a pending request stays up until it is served.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0; fav = 1'b0;
        ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
        for (int t = 0; t < 60; t++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1'b1;
                ra0 = 16'($urandom);
                rb0 = ($urandom_range(0, 3) == 0) ? ra0 : 16'($urandom);
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                pend1 = 1'b1;
                ra1 = 16'($urandom);
                rb1 = ($urandom_range(0, 3) == 0) ? (ra1 ^ 16'h000F) : 16'($urandom);
            end
            if (pend0) issue(1'b0, ra0, rb0);
            if (pend1) issue(1'b1, ra1, rb1);
            if (!pend0 && !pend1) begin
                @(negedge clk);
                check("rnd idle", {gnt0, gnt1, busy, done}, 0);
            end else begin
                if (pend0 && pend1) begin
                    w = fav;
                    fav = ~fav;
                end else begin
                    w = pend1;
                end
                runCompare($sformatf("rnd%0d", t), w,
                           w ? expCmp(ra1, rb1) : expCmp(ra0, rb0), 1'b1);
                if (w) pend1 = 1'b0; else pend0 = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
